// File: rtl/clkwiz_seq.sv
// Power-up / recovery sequencer for the clock wizard: pulses wiz_reset, waits for lock
// with timeout and bounded retries, then releases the downstream reset after a settle window.
// Latency: locked is seen 2 cycles late (synchronizer); outputs are registered state decodes.
// Backpressure: none; the block free-runs while enable=1, and enable=0 forces IDLE.
//
// Ports:
//   clk        - wizard input clock
//   reset_n    - synchronous active-low reset (priority over everything)
//   enable     - run/hold the sequence; low returns to IDLE and clears fail/retry_cnt
//   locked     - wizard lock, asynchronous to clk
//   wiz_reset  - active-high reset to the wizard (IDLE, RESET, FAIL)
//   rstn_out   - active-low reset for the derived-clock hierarchy (high only in RUN)
//   ready      - clock usable (RUN)
//   fail       - retries exhausted (FAIL), held until enable drops
//   lock_lost  - one-cycle pulse when lock drops during RUN
//   retry_cnt  - failed attempts in the current sequence
module clkwiz_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int SETTLE_CYCLES = 64,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       locked,
    output logic       wiz_reset,
    output logic       rstn_out,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_WAIT_LOCK,
        S_SETTLE,
        S_RUN,
        S_FAIL
    } state_t;

    // Terminal counts: the counter starts at 0 on state entry, so the N-th cycle
    // in a state is the one where cnt == N-1.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       retry_nxt;
    logic             lock_lost_nxt;
    logic             locked_m;
    logic             locked_s;

    // Saturating increment: a stuck counter is harmless, a wrapped one could
    // re-arm a terminal count.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            retry_cnt <= '0;
            lock_lost <= 1'b0;
            locked_m  <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            lock_lost <= lock_lost_nxt;
            locked_m  <= locked;
            locked_s  <= locked_m;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt_inc;
        retry_nxt     = retry_cnt;
        lock_lost_nxt = 1'b0;

        // enable wins over any same-cycle timeout or lock drop
        if (!enable) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_RESET;
                    cnt_nxt   = '0;
                end
                S_RESET: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = S_SETTLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TO_LAST) begin
                        retry_nxt = retry_cnt + 4'd1;
                        cnt_nxt   = '0;
                        state_nxt = (retry_nxt == RETRY_MAX) ? S_FAIL : S_RESET;
                    end
                end
                S_SETTLE: begin
                    // any unlocked cycle restarts both the settle window and the
                    // lock timeout, without charging a retry
                    if (!locked_s) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == SETTLE_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                        retry_nxt = '0;
                    end
                end
                S_RUN: begin
                    cnt_nxt = '0;
                    if (!locked_s) begin
                        state_nxt     = S_RESET;
                        lock_lost_nxt = 1'b1;
                    end
                end
                S_FAIL: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            endcase
        end
    end

    assign wiz_reset = (state == S_IDLE) || (state == S_RESET) || (state == S_FAIL);
    assign rstn_out  = (state == S_RUN);
    assign ready     = (state == S_RUN);
    assign fail      = (state == S_FAIL);

endmodule

// File: tb/tb_clkwiz_seq.sv
// Bench for clkwiz_seq: directed scenarios with hand-computed output-change events.
// Each change of the output vector is popped from an expected queue and checked for
// both value and cycle number.
module tb_clkwiz_seq;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int SETTLE_CYCLES = 8;
    localparam int MAX_RETRY     = 2;
    localparam int CNT_W         = 16;

    // Output vector: {wiz_reset, rstn_out, ready, fail, lock_lost, retry_cnt[3:0]}
    localparam logic [8:0] V_IDLE  = 9'b1_0_0_0_0_0000;
    localparam logic [8:0] V_WAIT0 = 9'b0_0_0_0_0_0000;
    localparam logic [8:0] V_RUN   = 9'b0_1_1_0_0_0000;
    localparam logic [8:0] V_LL    = 9'b1_0_0_0_1_0000;
    localparam logic [8:0] V_RST1  = 9'b1_0_0_0_0_0001;
    localparam logic [8:0] V_WAIT1 = 9'b0_0_0_0_0_0001;
    localparam logic [8:0] V_FAIL2 = 9'b1_0_0_1_0_0010;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] cyc;
        logic [8:0]  vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       locked;
    logic       wiz_reset;
    logic       rstn_out;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    clkwiz_seq #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY),
        .CNT_W        (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .locked   (locked),
        .wiz_reset(wiz_reset),
        .rstn_out (rstn_out),
        .ready    (ready),
        .fail     (fail),
        .lock_lost(lock_lost),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    bit         mon_en   = 1'b0;
    logic [8:0] prev     = 'x;
    logic [8:0] cur;
    exp_t       e_mon;

    // Monitor: every change of the output vector must match the next expected event.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {wiz_reset, rstn_out, ready, fail, lock_lost, retry_cnt};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%b want=no_change", cyc, cur);
                end else begin
                    e_mon = exp_q.pop_front();
                    if ((e_mon.cyc != 32'(cyc)) || (e_mon.vec !== cur)) begin
                        failures++;
                        $display("FAIL ev%0d got cyc=%0d vec=%b want cyc=%0d vec=%b",
                                 e_mon.id, cyc, cur, e_mon.cyc, e_mon.vec);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int id, input int c, input logic [8:0] vec);
        exp_t e;
        e.id  = 8'(id);
        e.cyc = 32'(c);
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int id);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_%0d pending=%0d want=0", id, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Drop enable and lock; IDLE is expected on the next edge.
    task automatic stop_seq(input int id);
        int s;
        s      = cyc;
        enable = 1'b0;
        locked = 1'b0;
        expect_at(id, s + 1, V_IDLE);
        goto(s + 5);
        drain(id);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d limit_reached", cyc);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int b;
        int r;
        reset_n = 1'b0;
        enable  = 1'b0;
        locked  = 1'b0;

        // Reset values; enable high under reset must not start the sequence
        goto(3);
        expect_at(0, cyc, V_IDLE);
        mon_en = 1'b1;
        enable = 1'b1;
        goto(6);
        drain(0);

        // 1. Happy path: RESET 4 cycles, lock 3 cycles after wiz_reset falls, 8 settle
        b = cyc;
        reset_n = 1'b1;
        expect_at(1, b + 5, V_WAIT0);
        expect_at(2, b + 19, V_RUN);
        goto(b + 8);
        locked = 1'b1;
        goto(b + 30);
        drain(1);

        // 5. Lock loss in RUN: single lock_lost pulse with rstn_out/ready low, rerun
        r = cyc;
        locked = 1'b0;
        expect_at(3, r + 3, V_LL);
        expect_at(4, r + 4, V_IDLE);
        expect_at(5, r + 7, V_WAIT0);
        expect_at(6, r + 18, V_RUN);
        goto(r + 7);
        locked = 1'b1;
        drain(5);
        stop_seq(50);

        // 4. Settle glitch on SETTLE cycle 5: settle restarts, RUN 6 cycles later
        b = cyc;
        enable = 1'b1;
        expect_at(7, b + 5, V_WAIT0);
        expect_at(8, b + 25, V_RUN);
        goto(b + 8);
        locked = 1'b1;
        goto(b + 13);
        locked = 1'b0;
        goto(b + 14);
        locked = 1'b1;
        drain(4);
        stop_seq(40);

        // 2. Timeout then retry success
        b = cyc;
        enable = 1'b1;
        expect_at(9, b + 5, V_WAIT0);
        expect_at(10, b + 25, V_RST1);
        expect_at(11, b + 29, V_WAIT1);
        expect_at(12, b + 43, V_RUN);
        goto(b + 32);
        locked = 1'b1;
        drain(2);
        stop_seq(20);

        // 3. Retry exhaustion: FAIL held while enable stays high
        b = cyc;
        enable = 1'b1;
        expect_at(13, b + 5, V_WAIT0);
        expect_at(14, b + 25, V_RST1);
        expect_at(15, b + 29, V_WAIT1);
        expect_at(16, b + 49, V_FAIL2);
        goto(b + 70);
        drain(3);
        stop_seq(30);

        // 6a. enable drop on the same edge as the final timeout: IDLE, not FAIL
        b = cyc;
        enable = 1'b1;
        expect_at(17, b + 5, V_WAIT0);
        expect_at(18, b + 25, V_RST1);
        expect_at(19, b + 29, V_WAIT1);
        expect_at(20, b + 49, V_IDLE);
        goto(b + 48);
        enable = 1'b0;
        drain(6);
        goto(cyc + 4);

        // 6b. reset_n in RUN on the same edge a lock drop would be seen: no lock_lost
        b = cyc;
        enable = 1'b1;
        expect_at(21, b + 5, V_WAIT0);
        expect_at(22, b + 19, V_RUN);
        goto(b + 8);
        locked = 1'b1;
        goto(b + 25);
        r = cyc;
        locked = 1'b0;
        expect_at(23, r + 3, V_IDLE);
        expect_at(24, r + 13, V_WAIT0);
        goto(r + 2);
        reset_n = 1'b0;
        goto(r + 8);
        reset_n = 1'b1;
        drain(61);
        goto(cyc + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
